// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: multi-cycle signed/unsigned multiply (radix-4 Booth) and
// divide (non-restoring) unit with a start/busy/done handshake.
// Ports:
//   clock, clear_n          clock, asynchronous active-low reset
//   start, op_div, is_signed request, 0=mul/1=div, signed operands
//   a, b                    multiplicand/dividend, multiplier/divisor
//   busy, done              operation in progress, one-cycle result pulse
//   div_by_zero             last divide had b == 0 (cleared on next accept)
//   hi, lo                  product[2W-1:W]/remainder, product[W-1:0]/quotient
module seq_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned EXT_W     = WIDTH + 2;               // Booth operand width
  localparam int unsigned ACC_HI_W  = EXT_W + 2;               // room for +/-2M
  localparam int unsigned ACC_W     = ACC_HI_W + EXT_W + 1;    // {A, Q, q_-1}
  localparam int unsigned REM_W     = WIDTH + 1;
  localparam int unsigned CNT_W     = $clog2(WIDTH + 1);
  localparam int unsigned MUL_STEPS = WIDTH / 2 + 1;

  typedef enum logic [2:0] {
    IDLE, MUL_ITER, DIV_ITER, DIV_ZERO, DIV_FIX, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [EXT_W-1:0]   mcand_q, mcand_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic               res_dbz_q, res_dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [ACC_HI_W-1:0] m_x, booth_add, booth_sum;
  logic [ACC_W-1:0]    booth_next;
  logic [REM_W-1:0]    dvsr_x, rem_sh, rem_next;
  logic [WIDTH-1:0]    quo_next, rem_mag;
  logic                a_neg, b_neg;
  logic [WIDTH-1:0]    a_mag, b_mag;

  // One radix-4 Booth step: add digit*M to the upper field, then arithmetic shift by 2
  always_comb begin : booth_step
    m_x       = {{2{mcand_q[EXT_W-1]}}, mcand_q};
    booth_add = '0;
    case (acc_q[2:0])
      3'b001, 3'b010: booth_add = m_x;
      3'b011:         booth_add = m_x << 1;
      3'b100:         booth_add = -(m_x << 1);
      3'b101, 3'b110: booth_add = -m_x;
      default:        booth_add = '0;
    endcase
    booth_sum  = acc_q[ACC_W-1 -: ACC_HI_W] + booth_add;
    booth_next = $signed({booth_sum, acc_q[EXT_W:0]}) >>> 2;
  end

  // One non-restoring step; quotient bit is 1 when the new remainder is non-negative
  always_comb begin : div_step
    dvsr_x   = {1'b0, dvsr_q};
    rem_sh   = {rem_q[REM_W-2:0], quo_q[WIDTH-1]};
    rem_next = rem_q[REM_W-1] ? rem_sh + dvsr_x : rem_sh - dvsr_x;
    quo_next = {quo_q[WIDTH-2:0], ~rem_next[REM_W-1]};
    rem_mag  = WIDTH'(rem_q[REM_W-1] ? rem_q + dvsr_x : rem_q);
  end

  // Operand magnitudes for the divide path
  always_comb begin : operand_prep
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // Next-state and datapath control
  always_comb begin : next_state
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    res_dbz_d = res_dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    done_d    = (state_q == DONE);

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          cnt_d = '0;
          dbz_d = 1'b0;
          if (!op_div) begin
            state_d = MUL_ITER;
            mcand_d = {{2{a_neg}}, a};
            acc_d   = {{ACC_HI_W{1'b0}}, {2{b_neg}}, b, 1'b0};
          end else if (b == '0) begin
            state_d = DIV_ZERO;
            quo_d   = a;                 // raw dividend is reported in hi
          end else begin
            state_d   = DIV_ITER;
            rem_d     = '0;
            quo_d     = a_mag;
            dvsr_d    = b_mag;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      MUL_ITER: begin
        acc_d = booth_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_STEPS - 1)) begin
          state_d   = DONE;
          res_hi_d  = booth_next[2*WIDTH:WIDTH+1];
          res_lo_d  = booth_next[WIDTH:1];
          res_dbz_d = 1'b0;
        end
      end
      DIV_ITER: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        state_d   = DONE;
        res_lo_d  = neg_quo_q ? -quo_q : quo_q;
        res_hi_d  = neg_rem_q ? -rem_mag : rem_mag;
        res_dbz_d = 1'b0;
      end
      DIV_ZERO: begin
        state_d   = DONE;
        res_hi_d  = quo_q;
        res_lo_d  = '1;
        res_dbz_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Results become visible only on the edge that raises done
    if (done_d) begin
      hi_d  = res_hi_q;
      lo_d  = res_lo_q;
      dbz_d = res_dbz_q;
    end
    busy_d = (state_d inside {MUL_ITER, DIV_ITER, DIV_ZERO, DIV_FIX}) && !done_d;
  end

  // State and output registers
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
      res_dbz_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      res_dbz_q <= res_dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
